// File: rtl/oled_init_seq.sv
// OLED panel power-up sequencer: pulses the panel reset, then streams command/data
// pairs from an external init ROM to a downstream writer, one pair per start pulse.
module oled_init_seq #(
   parameter int unsigned NUM_PAIRS    = 32,
   parameter int unsigned RESET_CYCLES = 1000,
   parameter int unsigned WAIT_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   output logic [5:0] rom_addr,
   input  logic [7:0] rom_dout,
   output logic       oled_res_n,
   output logic       start,
   output logic [7:0] command,
   output logic [7:0] data,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CntMax = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax) + 1;

   localparam logic [CntW-1:0] ResetLoad = CntW'(RESET_CYCLES - 1);
   localparam logic [CntW-1:0] WaitLoad  = CntW'(WAIT_CYCLES - 1);
   localparam logic [4:0]      LastIdx   = 5'(NUM_PAIRS - 1);

   typedef enum logic [2:0] {
      StResLow,
      StResWait,
      StFetch,
      StLatchCmd,
      StLatchData,
      StIssue,
      StWait,
      StDone
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [4:0]      idx_q;

   // All outputs are registered and updated on the transition into the state that owns them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StResLow;
         cnt_q      <= ResetLoad;
         idx_q      <= 5'd0;
         rom_addr   <= 6'd0;
         oled_res_n <= 1'b0;
         start      <= 1'b0;
         command    <= 8'd0;
         data       <= 8'd0;
         busy       <= 1'b1;
         done       <= 1'b0;
      end else begin
         start <= 1'b0;
         unique case (state_q)
            StResLow: begin
               if (cnt_q == '0) begin
                  state_q    <= StResWait;
                  cnt_q      <= ResetLoad;
                  oled_res_n <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StResWait: begin
               if (cnt_q == '0) begin
                  state_q  <= StFetch;
                  idx_q    <= 5'd0;
                  rom_addr <= 6'd0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StFetch: begin
               state_q  <= StLatchCmd;
               rom_addr <= {idx_q, 1'b1};
            end
            // ROM output lags the address by one cycle, so each latch sees the previous address.
            StLatchCmd: begin
               command <= rom_dout;
               state_q <= StLatchData;
            end
            StLatchData: begin
               data    <= rom_dout;
               state_q <= StIssue;
               start   <= 1'b1;
            end
            StIssue: begin
               cnt_q   <= WaitLoad;
               state_q <= StWait;
            end
            StWait: begin
               if (cnt_q == '0) begin
                  if (idx_q == LastIdx) begin
                     state_q <= StDone;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     idx_q    <= idx_q + 5'd1;
                     rom_addr <= {idx_q + 5'd1, 1'b0};
                     state_q  <= StFetch;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StDone: begin
               if (restart) begin
                  state_q    <= StResLow;
                  idx_q      <= 5'd0;
                  cnt_q      <= ResetLoad;
                  oled_res_n <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end
            default: state_q <= StResLow;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_init_seq.sv
// Bench for oled_init_seq: three parameterisations, each fed by a 1-cycle-latency ROM model.
module tb_oled_init_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic restart_a = 1'b0;
   logic restart_b = 1'b0;
   logic restart_c = 1'b0;

   logic [5:0] addr_a, addr_b, addr_c;
   logic [7:0] dout_a, dout_b, dout_c;
   logic       res_n_a, res_n_b, res_n_c;
   logic       start_a, start_b, start_c;
   logic [7:0] cmd_a, cmd_b, cmd_c;
   logic [7:0] dat_a, dat_b, dat_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;

   int cyc = 0;
   int base = 0;
   int total = 0;
   int bad = 0;
   int c_starts = 0;
   int b_starts = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   oled_init_seq dut_a (
      .clk(clk), .rst(rst), .restart(restart_a), .rom_addr(addr_a), .rom_dout(dout_a),
      .oled_res_n(res_n_a), .start(start_a), .command(cmd_a), .data(dat_a),
      .busy(busy_a), .done(done_a)
   );

   oled_init_seq #(.NUM_PAIRS(3), .RESET_CYCLES(4), .WAIT_CYCLES(6)) dut_b (
      .clk(clk), .rst(rst), .restart(restart_b), .rom_addr(addr_b), .rom_dout(dout_b),
      .oled_res_n(res_n_b), .start(start_b), .command(cmd_b), .data(dat_b),
      .busy(busy_b), .done(done_b)
   );

   oled_init_seq #(.NUM_PAIRS(1), .RESET_CYCLES(2), .WAIT_CYCLES(6)) dut_c (
      .clk(clk), .rst(rst), .restart(restart_c), .rom_addr(addr_c), .rom_dout(dout_c),
      .oled_res_n(res_n_c), .start(start_c), .command(cmd_c), .data(dat_c),
      .busy(busy_c), .done(done_c)
   );

   function automatic logic [7:0] rom_std(input logic [5:0] a);
      return a[0] ? {3'b000, a[5:1]} : 8'h80 + {3'b000, a[5:1]};
   endfunction

   // Registered ROMs: data appears one clock after the address.
   always @(posedge clk) begin
      dout_a <= rom_std(addr_a);
      dout_b <= rom_std(addr_b);
      dout_c <= (addr_c == 6'd0) ? 8'hAF : (addr_c == 6'd1) ? 8'h00 : 8'hFF;
   end

   typedef struct {
      int         cyc;
      logic       res_n;
      logic       start;
      logic       busy;
      logic       done;
      logic [5:0] addr;
      logic [7:0] cmd;
      logic [7:0] dat;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_res_n"}, res_n_a, 0);
      chk({tag, "_start"}, start_a, 0);
      chk({tag, "_busy"}, busy_a, 1);
      chk({tag, "_done"}, done_a, 0);
      chk({tag, "_addr"}, addr_a, 0);
      chk({tag, "_cmd"}, cmd_a, 0);
      chk({tag, "_data"}, dat_a, 0);
   endtask

   task automatic side_checks(input int rel);
      for (int j = 0; j < 16; j++) begin
         if (tbl[j].cyc == rel) begin
            chk($sformatf("b_res_n@%0d", rel), res_n_b, tbl[j].res_n);
            chk($sformatf("b_start@%0d", rel), start_b, tbl[j].start);
            chk($sformatf("b_busy@%0d", rel), busy_b, tbl[j].busy);
            chk($sformatf("b_done@%0d", rel), done_b, tbl[j].done);
            chk($sformatf("b_addr@%0d", rel), addr_b, tbl[j].addr);
            chk($sformatf("b_cmd@%0d", rel), cmd_b, tbl[j].cmd);
            chk($sformatf("b_data@%0d", rel), dat_b, tbl[j].dat);
         end
      end
      if (start_b) b_starts++;
      if (start_c) begin
         c_starts++;
         chk("c_start_cycle", rel, 7);
         chk("c_cmd", cmd_c, 8'hAF);
         chk("c_data", dat_c, 8'h00);
      end
      if (rel == 13) chk("c_done_early", done_c, 0);
      if (rel == 14) begin
         chk("c_done", done_c, 1);
         chk("c_busy", busy_c, 0);
      end
      if (rel == 60) begin
         chk("c_start_count", c_starts, 1);
         chk("b_start_count", b_starts, 3);
         chk("c_done_hold", done_c, 1);
      end
   endtask

   // Follows one full run of dut_a; rel 0 is the first RES_LOW cycle.
   task automatic run_a(input bit pulse_mid, input bit side);
      int  k = 0;
      int  last = 0;
      int  rel;
      bit  seen_done = 0;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         rel = cyc - base;
         if (pulse_mid) restart_a = (rel == 2066);
         if (side) side_checks(rel);
         if (rel == 0) begin
            chk("a_res_n_first", res_n_a, 0);
            chk("a_busy_first", busy_a, 1);
            chk("a_done_first", done_a, 0);
         end
         if (rel == 999) chk("a_res_n_low_end", res_n_a, 0);
         if (rel == 1000) chk("a_res_n_high", res_n_a, 1);
         if (start_a) begin
            if (k == 0) chk("a_first_start", rel, 2003);
            else chk($sformatf("a_period%0d", k), rel - last, 12);
            chk($sformatf("a_cmd%0d", k), cmd_a, 8'h80 + k);
            chk($sformatf("a_data%0d", k), dat_a, k);
            last = rel;
            k++;
         end
         if (done_a) begin
            chk("a_done_cycle", rel, 2384);
            chk("a_busy_done", busy_a, 0);
            chk("a_start_count", k, 32);
            seen_done = 1;
            break;
         end
      end
      restart_a = 1'b0;
      if (!seen_done) chk("a_done_timeout", 0, 1);
   endtask

   initial begin
      tbl[0]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 8'h00};
      tbl[1]  = '{3,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 8'h00};
      tbl[2]  = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 8'h00};
      tbl[3]  = '{8,  1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00, 8'h00};
      tbl[4]  = '{9,  1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 8'h00, 8'h00};
      tbl[5]  = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 8'h80, 8'h00};
      tbl[6]  = '{11, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 8'h80, 8'h00};
      tbl[7]  = '{12, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 8'h80, 8'h00};
      tbl[8]  = '{18, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 8'h80, 8'h00};
      tbl[9]  = '{19, 1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 8'h80, 8'h00};
      tbl[10] = '{20, 1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 8'h81, 8'h00};
      tbl[11] = '{21, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3, 8'h81, 8'h01};
      tbl[12] = '{31, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5, 8'h82, 8'h02};
      tbl[13] = '{37, 1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 8'h82, 8'h02};
      tbl[14] = '{38, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 8'h82, 8'h02};
      tbl[15] = '{45, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 8'h82, 8'h02};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_a("por");

      // Run 1: restart pulsed during WAIT of pair 5 must be ignored.
      @(posedge clk);
      #1 rst = 1'b1;
      base = cyc;
      run_a(1'b1, 1'b1);

      repeat (5) begin
         @(negedge clk);
         chk("a_done_hold", done_a, 1);
         chk("a_no_start_done", start_a, 0);
      end

      // Run 2: restart from DONE repeats the sequence.
      restart_a = 1'b1;
      @(posedge clk);
      #1 restart_a = 1'b0;
      base = cyc;
      run_a(1'b0, 1'b0);

      // Run 3: reset asserted during LATCH_DATA of pair 10.
      restart_a = 1'b1;
      @(posedge clk);
      #1 restart_a = 1'b0;
      base = cyc;
      for (int c = 0; c < 2200; c++) begin
         @(negedge clk);
         if (cyc - base == 2122) break;
      end
      chk("mid_position", cyc - base, 2122);
      chk("mid_cmd", cmd_a, 8'h8A);
      chk("mid_data", dat_a, 8'h09);
      rst = 1'b0;
      #1 chk_reset_a("mid_rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      base = cyc;
      run_a(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
